rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one resource among N requesters; sequential
//   companion to the combinational fixed-priority selector tree. Registered
//   one-hot grant, holds while the owner keeps req high, releases on done, req
//   drop, disable or hold timeout. Rotating pointer gives starvation freedom.
// PARAMETERS
//   N         8   requester count; power of two, 2..32
//   HOLD_MAX  15  max consecutive grant cycles per owner; 0 = no timeout
// PORTS
//   clock     in   1          system clock, rising edge
//   reset_n   in   1          asynchronous, active-low reset
//   en        in   1          arbiter enable; 0 = no new grants, force release
//   req       in   N          request vector, level-sensitive
//   done      in   1          owner releases the resource this cycle
//   gnt       out  N          registered one-hot grant, all-zero when idle
//   gnt_valid out  1          |gnt
//   gnt_idx   out  $clog2(N)  index of set gnt bit; 0 when idle
//   busy      out  1          state == GRANT
// BEHAVIOUR
// - Reset (async, reset_n=0): gnt=0, gnt_valid=0, gnt_idx=0, busy=0, ptr=0,
//   hold_cnt=0, state=IDLE. Takes effect immediately, including mid-grant.
// - Selection (comb.): hi=req_eff & {bits>=ptr}; winner = lowest set bit of hi
//   if hi!=0, else lowest set bit of req_eff. req_eff = req, except the current
//   owner's bit is forced 0 in its release cycle.
// - IDLE: en & |req at edge t -> gnt=onehot(winner) at t+1, state=GRANT,
//   hold_cnt=0. en=0 or req=0 -> stay IDLE, outputs 0.
// - GRANT: hold while en & req[gnt_idx] & ~done & ~timeout; hold_cnt++ per cycle
//   (saturates at HOLD_MAX). timeout = HOLD_MAX!=0 & hold_cnt==HOLD_MAX-1.
// - Release (any of: done, ~req[gnt_idx], ~en, timeout): ptr <= (gnt_idx+1)
//   mod N. If en & |req_eff: next winner granted at next edge (back-to-back,
//   no bubble), hold_cnt=0. Else gnt=0, state=IDLE.
// - ~en release always goes to IDLE regardless of req.
// - Simultaneous done and timeout: single release; identical result.
// - Owner's own req ignored in its release cycle: it cannot re-win immediately
//   even if it is the only requester; it may win again one cycle later from IDLE.
// - ptr wraps N-1 -> 0; ptr changes only on release.
// - gnt is always zero or one-hot; gnt_idx/gnt_valid/busy registered with gnt.
// - Latency: request to grant 1 cycle from IDLE; release to next grant 1 cycle.
// STRUCTURE
// - Package rr_arb_pkg: typedef enum logic {IDLE, GRANT} rr_state_t; helper
//   function for one-hot -> index; width localparams IDX_W=$clog2(N),
//   CNT_W=$clog2(HOLD_MAX+1).
// - Sub-module fp_sel #(N): combinational lowest-index-wins selector, outputs
//   one-hot + any; instantiated twice (masked and unmasked vectors).
// - Top: state/ptr/hold_cnt flops, release logic, output registers.
// TESTING
// 1. Assert reset_n=0 while gnt=8'h10 -> gnt=0, busy=0 same cycle without edge;
//    after release, req=8'h01 -> gnt=8'h01 next edge (ptr was reset to 0).
// 2. N=8, req=8'hFF held, done pulsed every GRANT cycle -> gnt_idx sequence
//    0,1,2,3,4,5,6,7,0 with no idle cycles between grants.
// 3. req=8'h10 only -> gnt=8'h10, gnt_idx=4 one cycle later; held 5 cycles;
//    drop req -> gnt=0, busy=0 next edge, ptr=5.
// 4. HOLD_MAX=4, req=8'h09 held, no done -> gnt=8'h01 for exactly 4 cycles,
//    then gnt=8'h08 for 4, then 8'h01 again; never a zero cycle.
// 5. Wrap: after grant to idx 5 released (ptr=6), req=8'h03 -> gnt=8'h01.
// 6. en=0 during grant to idx 2 with req=8'hFF -> gnt=0 next edge, ptr=3,
//    stays IDLE while en=0; en=1 -> gnt=8'h08.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, default widths and helpers for the round-robin arbiter
package rr_arb_pkg;

  typedef enum logic {IDLE, GRANT} rr_state_t;

  localparam int N_DEF        = 8;
  localparam int HOLD_MAX_DEF = 15;
  localparam int IDX_W        = $clog2(N_DEF);
  localparam int CNT_W        = $clog2(HOLD_MAX_DEF + 1);

  // One-hot (or zero) vector to bit index; an all-zero input maps to index 0.
  function automatic logic [4:0] oh2idx(input logic [31:0] oh);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) r = r | 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_fp_sel.sv
// rtl/rr_arbiter_fp_sel.sv - combinational lowest-index-wins selector
module fp_sel #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec_i,
  output logic [N-1:0] onehot_o,
  output logic         any_o
);

  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    onehot_o = vec_i & (~vec_i + N'(1));
    any_o    = |vec_i;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant and hold timeout
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  rr_state_t         state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic              timeout;
  logic              release_now;
  logic [N-1:0]      req_eff;
  logic [N-1:0]      mask;
  logic [N-1:0]      hi_oh, all_oh, winner;
  logic              hi_any, all_any;
  logic [IW-1:0]     win_idx;

  // Release detection; the owner's own request is hidden in its release cycle
  // so it cannot immediately re-win.
  always_comb begin
    timeout     = (HOLD_MAX != 0) && (cnt_q == CW'(HOLD_MAX - 1));
    release_now = (state_q == GRANT) && (!en || !req[idx_q] || done || timeout);
    req_eff     = release_now ? (req & ~gnt_q) : req;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr_q);
    end
  end

  fp_sel #(.N(N)) u_sel_hi (
    .vec_i    (req_eff & mask),
    .onehot_o (hi_oh),
    .any_o    (hi_any)
  );

  fp_sel #(.N(N)) u_sel_all (
    .vec_i    (req_eff),
    .onehot_o (all_oh),
    .any_o    (all_any)
  );

  // Prefer requesters at or above the pointer, otherwise wrap to the lowest.
  always_comb begin
    winner  = hi_any ? hi_oh : all_oh;
    win_idx = IW'(oh2idx(32'(winner)));
  end

  // Next-state: grant from idle, hold with saturating count, or hand over on release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (en && all_any) begin
          state_d = GRANT;
          gnt_d   = winner;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = idx_q + 1'b1;
          if (en && all_any) begin
            gnt_d = winner;
            idx_d = win_idx;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q != CW'(HOLD_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter against a rotating-priority model
module tb_rr_arbiter;

  logic       clock;
  logic       reset_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt, gnt4;
  logic       gnt_valid, gnt_valid4;
  logic [2:0] gnt_idx, gnt_idx4;
  logic       busy, busy4;

  int checks = 0;
  int failures = 0;

  rr_arbiter #(.N(8), .HOLD_MAX(15)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .busy(busy)
  );

  rr_arbiter #(.N(8), .HOLD_MAX(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .en(en), .req(req), .done(done),
    .gnt(gnt4), .gnt_valid(gnt_valid4), .gnt_idx(gnt_idx4), .busy(busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: owner (-1 = nobody), rotating start position, hold length.
  int m_owner[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_hm[2] = '{15, 4};
  logic [25:0] sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [12:0] exp_of(input int o);
    logic [7:0] oh;
    if (o < 0) return 13'd0;
    oh = 8'd0;
    oh[o] = 1'b1;
    return {1'b1, 1'b1, 3'(o), oh};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_cnt[k]   = 0;
    end
  endtask

  task automatic model_step(input int k, input logic e, input logic [7:0] r, input logic d);
    logic [7:0] reff;
    int p_old;
    bit rel;
    if (m_owner[k] < 0) begin
      if (e && r != 8'd0) begin
        m_owner[k] = pick(r, m_ptr[k]);
        m_cnt[k]   = 0;
      end
    end else begin
      rel = !e || !r[m_owner[k]] || d || (m_hm[k] != 0 && m_cnt[k] == m_hm[k] - 1);
      if (rel) begin
        p_old    = m_ptr[k];
        m_ptr[k] = (m_owner[k] + 1) % 8;
        reff     = r;
        reff[m_owner[k]] = 1'b0;
        if (e && reff != 8'd0) begin
          m_owner[k] = pick(reff, p_old);
          m_cnt[k]   = 0;
        end else begin
          m_owner[k] = -1;
        end
      end else if (m_cnt[k] < m_hm[k]) begin
        m_cnt[k]++;
      end
    end
  endtask

  // Drive one cycle of stimulus, push the expected post-edge outputs, wait to negedge.
  task automatic step(input logic e, input logic [7:0] r, input logic d);
    en = e; req = r; done = d;
    model_step(0, e, r, d);
    model_step(1, e, r, d);
    sbq.push_back({exp_of(m_owner[0]), exp_of(m_owner[1])});
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_async_gnt", 32'(gnt), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    chk("rst_async_gnt4", 32'(gnt4), 32'h0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: each cycle with a pending expectation, compare both arbiters.
  always @(posedge clock) begin
    logic [25:0] e;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_dut",  32'({busy,  gnt_valid,  gnt_idx,  gnt}),  32'(e[25:13]));
      chk("sb_dut4", 32'({busy4, gnt_valid4, gnt_idx4, gnt4}), 32'(e[12:0]));
    end
  end

  initial begin
    logic [7:0] rq;
    logic [7:0] exp4;
    reset_n = 1'b0; en = 1'b0; req = 8'd0; done = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Test 1: async reset mid-grant, pointer returns to 0
    step(1'b1, 8'h10, 1'b0);
    chk("t1_gnt10", 32'(gnt), 32'h10);
    do_reset();
    step(1'b1, 8'h01, 1'b0);
    chk("t1_gnt01", 32'(gnt), 32'h01);

    // Test 2: full rotation with done every grant cycle, no bubbles
    do_reset();
    step(1'b1, 8'hFF, 1'b0);
    chk("t2_idx0", 32'(gnt_idx), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'hFF, 1'b1);
      chk("t2_idx", 32'(gnt_idx), 32'(i % 8));
      chk("t2_valid", 32'(gnt_valid), 32'd1);
    end
    step(1'b1, 8'h00, 1'b0);

    // Test 3: single requester held, then drop; pointer lands on 5
    step(1'b1, 8'h10, 1'b0);
    chk("t3_idx4", 32'(gnt_idx), 32'd4);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h10, 1'b0);
      chk("t3_hold", 32'(gnt), 32'h10);
    end
    step(1'b1, 8'h00, 1'b0);
    chk("t3_drop_gnt", 32'(gnt), 32'h0);
    chk("t3_drop_busy", 32'(busy), 32'h0);
    step(1'b1, 8'h30, 1'b0);
    chk("t3_ptr5", 32'(gnt), 32'h20);

    // Test 5: pointer wraps past top, lowest requester wins
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    chk("t5_wrap", 32'(gnt), 32'h01);
    step(1'b1, 8'h00, 1'b0);

    // Test 6: disable during grant to idx 2
    step(1'b1, 8'h04, 1'b0);
    chk("t6_idx2", 32'(gnt_idx), 32'd2);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'hFF, 1'b0);
    chk("t6_off", 32'(gnt), 32'h0);
    step(1'b0, 8'hFF, 1'b0);
    chk("t6_stay", 32'(busy), 32'h0);
    step(1'b1, 8'hFF, 1'b0);
    chk("t6_regrant", 32'(gnt), 32'h08);
    step(1'b1, 8'h00, 1'b0);

    // Test 4: hold timeout of 4 alternates two requesters without gaps
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'h09, 1'b0);
      exp4 = (i < 4) ? 8'h01 : ((i < 8) ? 8'h08 : 8'h01);
      chk("t4_timeout", 32'(gnt4), 32'(exp4));
    end
    step(1'b1, 8'h00, 1'b0);

    // Random phase: sticky requests, varying done rate, occasional disable/reset
    rq = 8'h00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      if ($urandom_range(0, 249) == 0) do_reset();
      step($urandom_range(0, 9) != 0, rq,
           (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0));
    end

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
